uart_tx_frame: RTL and testbench

// - UART transmitter: the partner to the oversampled receive path. Serialises one byte per frame onto TX_OUT.
// - Frame is start(0), 8 data bits LSB first, optional parity, then stop(1).
// - Runs on the same oversampling CLK as the receiver; each bit is held for Prescale CLK cycles.
// - Sits between the host-side byte source (P_DATA/Data_Valid) and the serial line.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_parity.sv | 15 +
 rtl/uart_tx_frame.sv | 151 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM encoding, parity types and prescale floor.
// Imported by the TX frame path and the RX parity checker.
package uart_pkg;

  localparam int MIN_PRESCALE = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int I_IDLE   = 0;
  localparam int I_START  = 1;
  localparam int I_DATA   = 2;
  localparam int I_PARITY = 3;
  localparam int I_STOP   = 4;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_e;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity of a latched data word.
// Shared between the TX framer and the RX parity checker.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par_typ,
  output logic              par_bit
);

  assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity, stop.
// Each bit is held for the captured prescale count of CLK cycles.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_W-1:0]  P_DATA,
  input  logic               Data_Valid,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  output logic               TX_OUT,
  output logic               busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e             state_q;
  state_e             state_n;
  logic [PRESC_W-1:0] edge_q;
  logic [PRESC_W-1:0] edge_n;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_in;
  logic [BIT_W-1:0]   bit_q;
  logic [BIT_W-1:0]   bit_n;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  shift_n;
  logic               par_en_q;
  logic               par_typ_q;
  logic               par_bit;
  logic               bit_end;
  logic               last_bit;
  logic               accept;
  logic               tx_d;
  logic               busy_d;

  // Prescale below the floor would give too few samples at the receiver
  assign presc_in = (Prescale < PRESC_W'(MIN_PRESCALE))
                  ? PRESC_W'(MIN_PRESCALE) : Prescale;

  assign bit_end  = edge_q == (presc_q - PRESC_W'(1));
  assign last_bit = bit_q == BIT_W'(DATA_W - 1);
  assign accept   = Data_Valid &
                    (state_q[I_IDLE] | (state_q[I_STOP] & bit_end));

  uart_tx_parity #(
    .DATA_W(DATA_W)
  ) u_parity (
    .data   (data_q),
    .par_typ(par_typ_q),
    .par_bit(par_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q <= state_n;
      edge_q  <= edge_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      TX_OUT  <= tx_d;
      busy    <= busy_d;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        presc_q   <= presc_in;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    edge_n  = edge_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    if (!state_q[I_IDLE]) begin
      edge_n = bit_end ? '0 : edge_q + PRESC_W'(1);
    end
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (accept) begin
          state_n = S_START;
          bit_n   = '0;
          shift_n = P_DATA;
        end
      end
      state_q[I_START]: begin
        if (bit_end) state_n = S_DATA;
      end
      state_q[I_DATA]: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          bit_n   = bit_q + BIT_W'(1);
          if (last_bit) begin
            state_n = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      state_q[I_PARITY]: begin
        if (bit_end) state_n = S_STOP;
      end
      state_q[I_STOP]: begin
        if (bit_end) begin
          if (accept) begin
            state_n = S_START;
            bit_n   = '0;
            shift_n = P_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        edge_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (1'b1)
      state_n[I_IDLE]:   busy_d = 1'b0;
      state_n[I_START]:  tx_d   = 1'b0;
      state_n[I_DATA]:   tx_d   = shift_n[0];
      state_n[I_PARITY]: tx_d   = par_bit;
      state_n[I_STOP]:   tx_d   = 1'b1;
      default:           busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle waveform checks against a frame
// model, plus a behavioural receiver for random loopback traffic.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       TX_OUT;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_tx_frame dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int eff_p(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  // Parity bit that makes the count of ones even (pt=0) or odd (pt=1)
  function automatic logic par_of(input logic [7:0] d, input logic pt);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ^ pt;
  endfunction

  task automatic start(input logic [7:0] d, input logic pe,
                       input logic pt, input logic [5:0] p);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = p;
    Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
  endtask

  task automatic expect_frame(
    input logic [7:0] d, input logic pe, input logic pt, input int p,
    input int mid_presc, input bit noise, input bit chain,
    input logic [7:0] nd, input logic npe, input logic npt,
    input logic [5:0] np);
    logic bits[$];
    int pp;
    int len;
    pp = eff_p(p);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par_of(d, pt));
    bits.push_back(1'b1);
    len = bits.size() * pp;
    for (int k = 0; k < len; k++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== bits[k / pp]) begin
        errors++;
        $display("FAIL tx_bit d=%h k=%0d: got %b want %b",
                 d, k, TX_OUT, bits[k / pp]);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_frame d=%h k=%0d: got %b want 1",
                 d, k, busy);
      end
      if (noise && k == len / 2) begin
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom); Prescale = 6'($urandom);
        Data_Valid = 1'b1;
      end
      if (noise && k == len / 2 + 1) Data_Valid = 1'b0;
      if (mid_presc >= 0 && k == len / 2) Prescale = 6'(mid_presc);
      if (chain && k == len - 1) begin
        P_DATA = nd; PAR_EN = npe; PAR_TYP = npt; Prescale = np;
        Data_Valid = 1'b1;
      end
    end
    if (chain) begin
      @(posedge CLK); #1;
      Data_Valid = 1'b0;
    end else begin
      @(negedge CLK);
      checks++;
      if (busy !== 1'b0 || TX_OUT !== 1'b1) begin
        errors++;
        $display("FAIL frame_end d=%h: got busy=%b tx=%b want 0 1",
                 d, busy, TX_OUT);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tx=%b busy=%b want 1 0", TX_OUT, busy);
    end
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle: got tx=%b busy=%b want 1 0", TX_OUT, busy);
      end
    end
    start(8'h00, 1'b0, 1'b0, 6'd8);
    repeat (20) @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || TX_OUT !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_frame: got busy=%b tx=%b want 1 0", busy, TX_OUT);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got tx=%b busy=%b want 1 0", TX_OUT, busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: got tx=%b busy=%b want 1 0",
                 TX_OUT, busy);
      end
    end
  endtask

  task automatic test_basic();
    start(8'hA5, 1'b0, 1'b0, 6'd8);
    expect_frame(8'hA5, 1'b0, 1'b0, 8, -1, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
  endtask

  task automatic test_parity();
    start(8'h3C, 1'b1, 1'b0, 6'd8);
    expect_frame(8'h3C, 1'b1, 1'b0, 8, -1, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
    start(8'h3C, 1'b1, 1'b1, 6'd8);
    expect_frame(8'h3C, 1'b1, 1'b1, 8, -1, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic       rt;
    r  = 8'($urandom);
    rt = 1'($urandom);
    start(8'hA5, 1'b0, 1'b0, 6'd8);
    expect_frame(8'hA5, 1'b0, 1'b0, 8, -1, 1'b1, 1'b1,
                 8'hFF, 1'b0, 1'b0, 6'd8);
    expect_frame(8'hFF, 1'b0, 1'b0, 8, -1, 1'b1, 1'b1,
                 r, 1'b1, rt, 6'd12);
    expect_frame(r, 1'b1, rt, 12, -1, 1'b1, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
  endtask

  task automatic test_min_prescale();
    start(8'h96, 1'b1, 1'b0, 6'd2);
    expect_frame(8'h96, 1'b1, 1'b0, 2, -1, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
    start(8'h1E, 1'b0, 1'b0, 6'd0);
    expect_frame(8'h1E, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
    start(8'hE1, 1'b0, 1'b0, 6'd4);
    expect_frame(8'hE1, 1'b0, 1'b0, 4, -1, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
  endtask

  task automatic test_prescale_change();
    start(8'h5A, 1'b0, 1'b0, 6'd8);
    expect_frame(8'h5A, 1'b0, 1'b0, 8, 16, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
    start(8'hC3, 1'b0, 1'b0, 6'd16);
    expect_frame(8'hC3, 1'b0, 1'b0, 16, -1, 1'b0, 1'b0,
                 8'h00, 1'b0, 1'b0, 6'd8);
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] d;
      logic       pe;
      logic       pt;
      int         p;
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      p  = int'($urandom_range(1, 20));
      start(d, pe, pt, 6'(p));
      expect_frame(d, pe, pt, p, -1, 1'b1, 1'b0,
                   8'h00, 1'b0, 1'b0, 6'd8);
    end
  endtask

  task automatic rx_byte(input int p, input logic pe, input logic pt,
                         output logic [7:0] d, output bit par_ok);
    int t;
    int ones;
    d = '0; par_ok = 1'b1; t = 0; ones = 0;
    while (TX_OUT !== 1'b0 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL rx_start_timeout: got no start want start");
      par_ok = 1'b0;
      return;
    end
    repeat (p / 2) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      repeat (p) @(negedge CLK);
      d[i] = TX_OUT;
      ones += int'(TX_OUT);
    end
    if (pe) begin
      repeat (p) @(negedge CLK);
      ones += int'(TX_OUT);
      par_ok = (((ones % 2) == 1) == pt);
    end
    repeat (p) @(negedge CLK);
    if (TX_OUT !== 1'b1) par_ok = 1'b0;
    t = 0;
    while (busy === 1'b1 && t < 100) begin
      @(negedge CLK);
      t++;
    end
  endtask

  task automatic test_loopback();
    int plist[3] = '{8, 16, 32};
    for (int n = 0; n < 256; n++) begin
      logic [7:0] d;
      logic [7:0] got;
      logic       pe;
      logic       pt;
      bit         ok;
      int         p;
      p  = plist[n % 3];
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      start(d, pe, pt, 6'(p));
      rx_byte(p, pe, pt, got, ok);
      checks++;
      if (got !== d) begin
        errors++;
        $display("FAIL loopback_data n=%0d p=%0d: got %h want %h",
                 n, p, got, d);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL loopback_parity n=%0d p=%0d: got error want none",
                 n, p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_min_prescale();
    test_prescale_change();
    test_random_frames();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
